// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO,
// with registered RTS flow control and one-cycle frame-error / overflow pulses.
module uart_rx_fifo #(
   parameter int DIV        = 868,
   parameter int DEPTH      = 16,
   parameter int RTS_MARGIN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_rts,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overflow
);
   localparam int CNT_W = $clog2(DIV);
   localparam int PTR_W = $clog2(DEPTH);
   // Counter counts down to zero, so loads are one less than the wanted interval.
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
   localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);
   // (DEPTH - count) < RTS_MARGIN  is the same as  count > DEPTH - RTS_MARGIN
   localparam logic [PTR_W:0]   RTS_THR   = (PTR_W + 1)'(DEPTH - RTS_MARGIN);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic             sync1_q, line_q, line_prev_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       shift_q;
   logic             frame_err_q;

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, rts_q;

   logic             expire, push, pop, full, accept;

   assign expire = (cnt_q == '0);
   assign push   = (state_q == STOP) && expire && line_q;
   assign pop    = rx_valid && rx_ready;
   assign full   = (count_q == DEPTH_C);
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign accept = push && (!full || pop);

   // Two-flop synchronizer plus one more sample for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         line_q      <= 1'b1;
         line_prev_q <= 1'b1;
      end else begin
         sync1_q     <= uart_rxd;
         line_q      <= sync1_q;
         line_prev_q <= line_q;
      end
   end

   // Receive FSM: mid-bit sampling driven by a down-counter and bit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A held-low line (break) has no edge here, so it cannot re-trigger.
               if (line_prev_q && !line_q) begin
                  state_q <= START;
                  cnt_q   <= HALF_LOAD;
               end
            end
            START: begin
               if (expire) begin
                  if (!line_q) begin
                     state_q <= DATA;
                     cnt_q   <= FULL_LOAD;
                     idx_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DATA: begin
               if (expire) begin
                  cnt_q <= FULL_LOAD;
                  idx_q <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            STOP: begin
               if (expire) begin
                  state_q     <= IDLE;
                  frame_err_q <= !line_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Data bits land LSB first at their index on each mid-bit sample.
   always_ff @(posedge clk) begin
      if (state_q == DATA && expire) shift_q[idx_q] <= line_q;
   end

   // FIFO storage write; contents are meaningful only below count.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= shift_q;
   end

   // Occupancy next-state from accepted pushes and pops.
   always_comb begin
      count_d = count_q;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (!accept && pop) count_d = count_q - 1'b1;
   end

   // FIFO pointers, count, overflow pulse and RTS register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rts_q      <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         overflow_q <= push && full && !pop;
         rts_q      <= (count_q > RTS_THR);
      end
   end

   assign rx_valid  = (count_q != '0);
   assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign uart_rts  = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: serial-line driver with a queue-based scoreboard for uart_rx_fifo.
module tb_uart_rx_fifo;
   localparam int DIV    = 16;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 4;
   // Edges from the first edge that clocks a low rxd to the stop-bit sample edge.
   localparam int LAT    = 2 + DIV / 2 + 9 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic       uart_rts, rx_valid, frame_err, overflow;
   logic [7:0] rx_data;

   uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
      .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_rts(uart_rts),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         e;
      logic [7:0] b;
      bit         ok;
   } ev_t;

   ev_t        ev_q[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         ferr_cnt = 0, ovf_cnt = 0, pop_cnt = 0;
   bit         exp_ferr = 0, exp_ovf = 0, exp_rts = 0;
   bit         rand_done = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Serialize one 8N1 frame; the expected outcome is queued at the stop-sample edge.
   task automatic send(input logic [7:0] b, input bit stop_ok);
      ev_t ev;
      tick();
      uart_rxd = 1'b0;
      ev.e = cyc + 1 + LAT;
      ev.b = b;
      ev.ok = stop_ok;
      ev_q.push_back(ev);
      repeat (DIV) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (DIV) tick();
      end
      uart_rxd = stop_ok;
      repeat (DIV) tick();
      uart_rxd = 1'b1;
      if (!stop_ok) repeat (DIV) tick();
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      repeat (DEPTH + 4) tick();
      check("drain_empty", rx_valid, 0);
   endtask

   initial begin : clock_count
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: compares DUT outputs each cycle against the reference FIFO queue.
   initial begin : monitor
      ev_t ev;
      bit  pop_now, full_now;
      forever begin
         @(negedge clk);
         check("rx_valid", rx_valid, exp_q.size() > 0);
         check("uart_rts", uart_rts, exp_rts);
         check("frame_err", frame_err, exp_ferr);
         check("overflow", overflow, exp_ovf);
         if (frame_err) ferr_cnt++;
         if (overflow) ovf_cnt++;
         if (rx_valid && rx_ready) pop_cnt++;
         exp_ferr = 1'b0;
         exp_ovf  = 1'b0;
         exp_rts  = (DEPTH - exp_q.size()) < MARGIN;
         if (rst) begin
            exp_q.delete();
            ev_q.delete();
            exp_rts = 1'b0;
         end else begin
            full_now = (exp_q.size() == DEPTH);
            pop_now  = (exp_q.size() > 0) && rx_ready;
            if (pop_now) begin
               if (rx_valid) check("rx_data", rx_data, exp_q[0]);
               void'(exp_q.pop_front());
            end
            if (ev_q.size() > 0 && ev_q[0].e == cyc + 1) begin
               ev = ev_q.pop_front();
               if (!ev.ok)                  exp_ferr = 1'b1;
               else if (full_now && !pop_now) exp_ovf = 1'b1;
               else                          exp_q.push_back(ev.b);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int base_f, base_o, base_p, k, t;

      // Reset behaviour
      repeat (4) tick();
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 8'h00);
      check("rst_rts", uart_rts, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      repeat (4) tick();

      // 0xA5 with exact latency and single-cycle valid
      rx_ready = 1'b1;
      fork
         send(8'hA5, 1'b1);
         begin : lat
            k = -1;
            t = -1;
            for (int i = 0; i < 50 && k < 0; i++) begin
               @(negedge clk);
               if (!uart_rxd) k = cyc;
            end
            for (int i = 0; i < 300 && t < 0; i++) begin
               @(negedge clk);
               if (rx_valid) t = cyc;
            end
            check("a5_latency", t - (k + 1), 154);
            check("a5_data", rx_data, 8'hA5);
            @(negedge clk);
            check("a5_one_cycle", rx_valid, 0);
         end
      join
      repeat (4) tick();

      // Short glitch is a false start; the next frame still arrives
      base_f = ferr_cnt; base_p = pop_cnt;
      tick();
      uart_rxd = 1'b0;
      repeat (4) tick();
      uart_rxd = 1'b1;
      repeat (3 * DIV) tick();
      check("glitch_no_push", pop_cnt - base_p, 0);
      check("glitch_no_ferr", ferr_cnt - base_f, 0);
      send(8'h5A, 1'b1);
      repeat (4) tick();
      check("after_glitch_pops", pop_cnt - base_p, 1);

      // Bad stop bit then good frame
      base_f = ferr_cnt; base_p = pop_cnt;
      send(8'h3C, 1'b0);
      check("ferr_single", ferr_cnt - base_f, 1);
      check("ferr_no_push", pop_cnt - base_p, 0);
      send(8'h42, 1'b1);
      repeat (4) tick();
      check("after_ferr_pops", pop_cnt - base_p, 1);

      // Break: line held low yields one frame_err only
      base_f = ferr_cnt;
      tick();
      uart_rxd = 1'b0;
      k = cyc;
      ev_q.push_back('{e: k + 1 + LAT, b: 8'h00, ok: 1'b0});
      repeat (30 * DIV) tick();
      uart_rxd = 1'b1;
      repeat (DIV) tick();
      check("break_single_ferr", ferr_cnt - base_f, 1);

      // Fill past capacity with no consumer
      rx_ready = 1'b0;
      base_o = ovf_cnt; base_p = pop_cnt;
      for (int i = 0; i < 17; i++) begin
         send(8'(i), 1'b1);
         if (i == 11) check("rts_after_12", uart_rts, 0);
         if (i == 12) check("rts_after_13", uart_rts, 1);
      end
      check("ovf_on_17th", ovf_cnt - base_o, 1);
      drain();
      check("fill_pops", pop_cnt - base_p, 16);

      // Full FIFO with a pop coinciding with the stop sample
      rx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 255)), 1'b1);
      base_o = ovf_cnt; base_p = pop_cnt;
      fork
         send(8'h99, 1'b1);
         begin : fp
            k = -1;
            for (int i = 0; i < 50 && k < 0; i++) begin
               @(negedge clk);
               if (!uart_rxd) k = cyc;
            end
            check("fp_start_seen", k >= 0, 1);
            if (k >= 0) begin
               while (cyc < k + LAT) tick();
               rx_ready = 1'b1;
               tick();
               rx_ready = 1'b0;
            end
         end
      join
      check("fp_no_ovf", ovf_cnt - base_o, 0);
      check("fp_rts_still_full", uart_rts, 1);
      drain();
      check("fp_pops", pop_cnt - base_p, 1 + DEPTH);

      // Reset in the middle of bit 4 of a frame
      rx_ready = 1'b0;
      for (int i = 0; i < 14; i++) send(8'(8'hC0 + i), 1'b1);
      base_f = ferr_cnt; base_o = ovf_cnt;
      tick();
      uart_rxd = 1'b0;
      repeat (DIV) tick();
      for (int i = 0; i < 4; i++) begin
         uart_rxd = 1'(8'hEE >> i);
         repeat (DIV) tick();
      end
      uart_rxd = 1'b0;
      repeat (DIV / 2) tick();
      rst = 1'b1;
      uart_rxd = 1'b1;
      repeat (3) tick();
      check("midrst_data_zero", rx_data, 8'h00);
      rst = 1'b0;
      repeat (2 * DIV) tick();
      check("midrst_valid", rx_valid, 0);
      check("midrst_rts", uart_rts, 0);
      send(8'h81, 1'b1);
      check("post_rst_valid", rx_valid, 1);
      check("post_rst_data", rx_data, 8'h81);
      check("midrst_no_pulses", (ferr_cnt - base_f) + (ovf_cnt - base_o), 0);
      drain();

      // Randomized traffic with a random consumer
      fork
         begin : rand_tx
            for (int n = 0; n < 30; n++) begin
               send(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
               repeat ($urandom_range(0, 20)) tick();
            end
            rand_done = 1'b1;
         end
         begin : rand_rx
            while (!rand_done) begin
               rx_ready = ($urandom_range(0, 3) == 0);
               tick();
            end
         end
      join
      drain();
      check("final_pending", ev_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
